instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
Fetch stage that sits directly upstream of the instruction decoder. It holds the PC and issues single-outstanding word fetches to instruction memory over a req/ack handshake. Returned words and their PCs are buffered in a small FIFO, which drives the decoder through a valid/ready interface. Supports a branch/jump redirect that flushes all in-flight and buffered work.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0
FIFO_DEPTH, 2, fetch buffer entries; power of two, at least 2

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous, active-high reset
imem_req  output  1  fetch request; held high until accepted
imem_addr  output  32  word-aligned fetch address; stable while imem_req=1
imem_ack  input  1  memory accepts and completes the request this cycle; imem_rdata valid
imem_rdata  input  32  fetched instruction word
redirect_valid  input  1  one-cycle pulse: change fetch path
redirect_pc  input  32  new fetch address; bits [1:0] are ignored and forced to 0
instr_valid  output  1  FIFO head valid toward decoder
instr  output  32  FIFO head instruction word
instr_pc  output  32  PC of the FIFO head
instr_ready  input  1  decoder consumes the head when instr_valid=1

Behaviour:
- Reset (rst=1 at edge):
  - state=IDLE, pc=RESET_PC, FIFO emptied (count=0).
  - Outputs: imem_req=0, instr_valid=0, imem_addr=RESET_PC; instr and instr_pc are don't-care but driven to 0.
  - Reset mid-transaction abandons any outstanding request; memory must tolerate imem_req dropping.
- imem_addr = pc at all times.
- imem_req = 1 in FETCH and DROP, else 0.
- FSM states: IDLE, FETCH, DROP.
  - IDLE: if redirect_valid, pc<=redirect_pc and stay IDLE. Otherwise go to FETCH when count<FIFO_DEPTH.
  - FETCH, imem_ack=1, no redirect:
    - Push {imem_rdata, pc} into the FIFO; pc<=pc+4 (mod 2^32, wraps 0xFFFF_FFFC->0).
    - Stay in FETCH if the post-update count<FIFO_DEPTH, else go to IDLE.
  - FETCH, no ack, redirect_valid: pc stays (address must remain stable); go to DROP; latch redirect_pc into pending_pc.
  - FETCH, ack and redirect in the same cycle: discard the data, pc<=redirect_pc, go to IDLE.
  - DROP: wait for imem_ack; discard the data; pc<=pending_pc; go to IDLE. A further redirect while in DROP overwrites pending_pc. A redirect in the ack cycle uses the new redirect_pc.
- FIFO:
  - Pop when instr_valid & instr_ready. Push and pop in the same cycle are allowed; count is unchanged.
  - Full: no request is issued (IDLE holds). There is never a push when full, by construction.
  - Empty: instr_valid=0.
  - Pointers wrap modulo FIFO_DEPTH.
- Redirect flushes the FIFO that edge; instr_valid=0 the next cycle. A handshake in the redirect cycle counts as consumed; the flush still clears the remainder.
- Latency:
  - Reset released at cycle 0 -> IDLE; imem_req=1 in cycle 1.
  - Ack in cycle k -> instr_valid=1 in cycle k+1.
  - Zero-wait memory with instr_ready held high sustains one instruction per cycle after the first, except for the IDLE bubble taken only when the FIFO is full.
- Only one request is outstanding; there is never a second request before an ack.

Test Plan:
- Reset with RESET_PC=0x100, imem_ack tied 1, instr_ready=1 -> imem_addr 0x100,0x104,0x108 on consecutive cycles from cycle 1; instr_pc 0x100 appears in cycle 2 with the matching rdata.
- instr_ready=0, ack always 1 -> exactly 2 pushes (0x0,0x4), then imem_req=0 and the FSM is IDLE. Raising ready drains in order, and fetching resumes at 0x8.
- Memory with 3-cycle ack latency -> imem_addr is held stable during the wait; each instruction appears 1 cycle after its ack.
- redirect_pc=0x2002 while in FETCH waiting for ack -> old address held until ack and its data dropped; next request to 0x2000; FIFO empty the cycle after the redirect.
- Redirect coinciding with ack, and a second redirect (0x300 then 0x400) while in DROP -> no stale instruction delivered; next fetch at 0x400.
- pc=0xFFFF_FFFC fetch -> next imem_addr 0x0000_0000; assert rst mid-wait -> imem_req=0 and instr_valid=0 the next cycle.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the PC, issues one outstanding word fetch at a time and
// buffers returned {instr, pc} pairs in a small FIFO that feeds the decoder.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        instr_valid,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        instr_ready
);

    localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StFetch = 2'd1;
    localparam logic [1:0] StDrop  = 2'd2;

    logic [1:0]       r_state;
    logic [31:0]      r_pc;
    logic [31:0]      r_pending_pc;
    logic [31:0]      r_mem_instr [FIFO_DEPTH];
    logic [31:0]      r_mem_pc    [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic [1:0]       w_state_next;
    logic [31:0]      w_pc_next;
    logic [31:0]      w_pending_next;
    logic [31:0]      w_redirect_pc;
    logic [CNT_W-1:0] w_count_next;
    logic [CNT_W-1:0] w_count_after_push;
    logic             w_push;
    logic             w_pop;
    logic             w_flush;

    assign w_redirect_pc = redirect_pc & 32'hFFFF_FFFC;
    assign w_flush       = redirect_valid;
    assign w_pop         = instr_valid & instr_ready;
    assign w_push        = (r_state == StFetch) & imem_ack & ~redirect_valid;

    // Occupancy once this cycle's push lands, net of any concurrent pop.
    assign w_count_after_push = w_pop ? r_count : r_count + CNT_W'(1);

    always_comb begin
        w_state_next   = r_state;
        w_pc_next      = r_pc;
        w_pending_next = r_pending_pc;
        case (r_state)
            StIdle: begin
                if (redirect_valid) begin
                    w_pc_next = w_redirect_pc;
                end else if (r_count < DEPTH_C) begin
                    w_state_next = StFetch;
                end
            end
            StFetch: begin
                if (imem_ack) begin
                    if (redirect_valid) begin
                        w_pc_next    = w_redirect_pc;
                        w_state_next = StIdle;
                    end else begin
                        w_pc_next    = r_pc + 32'd4;
                        w_state_next = (w_count_after_push < DEPTH_C) ? StFetch : StIdle;
                    end
                end else if (redirect_valid) begin
                    // Address must stay put until the outstanding request completes.
                    w_pending_next = w_redirect_pc;
                    w_state_next   = StDrop;
                end
            end
            StDrop: begin
                if (imem_ack) begin
                    w_pc_next    = redirect_valid ? w_redirect_pc : r_pending_pc;
                    w_state_next = StIdle;
                end else if (redirect_valid) begin
                    w_pending_next = w_redirect_pc;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_comb begin
        w_count_next = r_count;
        if (w_flush) begin
            w_count_next = '0;
        end else if (w_push && !w_pop) begin
            w_count_next = r_count + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            w_count_next = r_count - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= StIdle;
            r_pc         <= RESET_PC;
            r_pending_pc <= RESET_PC;
        end else begin
            r_state      <= w_state_next;
            r_pc         <= w_pc_next;
            r_pending_pc <= w_pending_next;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count <= w_count_next;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_instr[r_wr_ptr] <= imem_rdata;
            r_mem_pc[r_wr_ptr]    <= r_pc;
        end
    end

    assign imem_req    = (r_state == StFetch) || (r_state == StDrop);
    assign imem_addr   = r_pc;
    assign instr_valid = (r_count != '0);
    assign instr       = instr_valid ? r_mem_instr[r_rd_ptr] : 32'd0;
    assign instr_pc    = instr_valid ? r_mem_pc[r_rd_ptr] : 32'd0;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios with literal expectations, then randomized
// traffic checked every cycle against a transaction-level model of the fetch stage.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC_C = 32'h0000_0100;
    localparam int DEPTH = 2;

    typedef struct packed {
        logic [31:0] ins;
        logic [31:0] pc;
    } ent_t;

    logic        clk;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic [31:0] salt;

    int n_vec;
    int n_err;

    // Model state: request outstanding, outstanding result to be discarded, target after drop.
    logic [31:0] m_pc;
    logic [31:0] m_pend;
    logic        m_busy;
    logic        m_discard;
    logic        m_known;
    ent_t        m_q[$];
    int          m_sz0;
    logic [31:0] m_rp;
    ent_t        m_head;

    instr_fetch_unit #(
        .RESET_PC   (RESET_PC_C),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ack       (imem_ack),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr          (instr),
        .instr_pc       (instr_pc),
        .instr_ready    (instr_ready)
    );

    // Memory word is a fixed function of the address, optionally scrambled per cycle.
    assign imem_rdata = {~imem_addr[15:0], imem_addr[15:0]} ^ salt;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_pc      = RESET_PC_C;
            m_pend    = RESET_PC_C;
            m_busy    = 1'b0;
            m_discard = 1'b0;
            m_q.delete();
            m_known   = 1'b1;
        end else if (m_known) begin
            m_sz0 = m_q.size();
            m_rp  = redirect_pc & 32'hFFFF_FFFC;
            if (m_sz0 > 0 && instr_ready) void'(m_q.pop_front());
            if (!m_busy) begin
                if (redirect_valid) m_pc = m_rp;
                else if (m_sz0 < DEPTH) m_busy = 1'b1;
            end else if (!m_discard) begin
                if (imem_ack && !redirect_valid) begin
                    m_q.push_back({imem_rdata, m_pc});
                    m_pc   = m_pc + 32'd4;
                    m_busy = (m_q.size() < DEPTH);
                end else if (imem_ack) begin
                    m_pc   = m_rp;
                    m_busy = 1'b0;
                end else if (redirect_valid) begin
                    m_discard = 1'b1;
                    m_pend    = m_rp;
                end
            end else begin
                if (imem_ack) begin
                    m_pc      = redirect_valid ? m_rp : m_pend;
                    m_busy    = 1'b0;
                    m_discard = 1'b0;
                end else if (redirect_valid) begin
                    m_pend = m_rp;
                end
            end
            if (redirect_valid) m_q.delete();
        end
    end

    always @(negedge clk) begin
        if (m_known) begin
            m_head = (m_q.size() > 0) ? m_q[0] : '0;
            check("m_req", 32'(imem_req), 32'(m_busy));
            check("m_addr", imem_addr, m_pc);
            check("m_valid", 32'(instr_valid), 32'(m_q.size() > 0));
            check("m_instr", instr, m_head.ins);
            check("m_instr_pc", instr_pc, m_head.pc);
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        m_known = 1'b0;
        rst = 1'b1;
        imem_ack = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = 32'd0;
        instr_ready = 1'b1;
        salt = 32'd0;

        repeat (2) tick();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_valid", 32'(instr_valid), 32'd0);
        check("rst_addr", imem_addr, 32'h0000_0100);
        check("rst_instr", instr, 32'd0);
        rst = 1'b0;
        imem_ack = 1'b1;

        // Zero-wait memory, ready high: back-to-back fetches.
        tick();
        check("seq_addr0", imem_addr, 32'h0000_0100);
        check("seq_req0", 32'(imem_req), 32'd1);
        tick();
        check("seq_addr1", imem_addr, 32'h0000_0104);
        check("seq_pc0", instr_pc, 32'h0000_0100);
        check("seq_instr0", instr, 32'hFEFF_0100);
        tick();
        check("seq_addr2", imem_addr, 32'h0000_0108);
        check("seq_pc1", instr_pc, 32'h0000_0104);

        // Redirect with ack to 0, then fill the FIFO with ready low.
        redirect_valid = 1'b1;
        redirect_pc = 32'd0;
        instr_ready = 1'b0;
        tick();
        redirect_valid = 1'b0;
        repeat (5) tick();
        check("full_req", 32'(imem_req), 32'd0);
        check("full_addr", imem_addr, 32'h0000_0008);
        check("full_pc", instr_pc, 32'h0000_0000);
        check("full_instr", instr, 32'hFFFF_0000);
        instr_ready = 1'b1;
        tick();
        check("drain_pc", instr_pc, 32'h0000_0004);
        check("drain_instr", instr, 32'hFFFB_0004);
        imem_ack = 1'b0;

        // Slow memory: address held until the ack.
        tick();
        check("wait_req", 32'(imem_req), 32'd1);
        check("wait_addr0", imem_addr, 32'h0000_0008);
        check("wait_valid", 32'(instr_valid), 32'd0);
        tick();
        check("wait_addr1", imem_addr, 32'h0000_0008);
        tick();
        check("wait_addr2", imem_addr, 32'h0000_0008);
        imem_ack = 1'b1;
        tick();
        check("late_valid", 32'(instr_valid), 32'd1);
        check("late_pc", instr_pc, 32'h0000_0008);
        check("late_instr", instr, 32'hFFF7_0008);
        imem_ack = 1'b0;

        // Redirect while waiting: hold old address, drop its data.
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_2002;
        tick();
        redirect_valid = 1'b0;
        check("drop_valid", 32'(instr_valid), 32'd0);
        check("drop_req", 32'(imem_req), 32'd1);
        check("drop_addr0", imem_addr, 32'h0000_000C);
        tick();
        check("drop_addr1", imem_addr, 32'h0000_000C);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        check("drop_done_req", 32'(imem_req), 32'd0);
        check("drop_new_addr", imem_addr, 32'h0000_2000);
        check("drop_done_valid", 32'(instr_valid), 32'd0);
        tick();
        check("refetch_req", 32'(imem_req), 32'd1);
        check("refetch_addr", imem_addr, 32'h0000_2000);

        // Redirect coinciding with ack, then two redirects while dropping.
        imem_ack = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0300;
        tick();
        redirect_valid = 1'b0;
        imem_ack = 1'b0;
        check("coin_valid", 32'(instr_valid), 32'd0);
        check("coin_addr", imem_addr, 32'h0000_0300);
        tick();
        check("coin_fetch", imem_addr, 32'h0000_0300);
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_0280;
        tick();
        check("drop2_hold", imem_addr, 32'h0000_0300);
        redirect_pc = 32'h0000_0400;
        tick();
        redirect_valid = 1'b0;
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        check("drop2_req", 32'(imem_req), 32'd0);
        check("drop2_addr", imem_addr, 32'h0000_0400);
        check("drop2_valid", 32'(instr_valid), 32'd0);

        // PC wrap, then reset mid-wait.
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect_valid = 1'b0;
        check("wrap_base", imem_addr, 32'hFFFF_FFFC);
        tick();
        check("wrap_req", 32'(imem_req), 32'd1);
        imem_ack = 1'b1;
        tick();
        imem_ack = 1'b0;
        check("wrap_addr", imem_addr, 32'h0000_0000);
        check("wrap_pc", instr_pc, 32'hFFFF_FFFC);
        tick();
        check("mid_req", 32'(imem_req), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst2_req", 32'(imem_req), 32'd0);
        check("rst2_valid", 32'(instr_valid), 32'd0);
        check("rst2_addr", imem_addr, 32'h0000_0100);

        // Randomized traffic checked by the model.
        for (int i = 0; i < 3000; i++) begin
            int ack_pct;
            int rdy_pct;
            ack_pct = (((i / 500) % 3) == 0) ? 100 : ((((i / 500) % 3) == 1) ? 50 : 20);
            rdy_pct = (((i / 300) % 2) == 0) ? 90 : 30;
            rst = ($urandom_range(199, 0) == 0);
            imem_ack = imem_req && ($urandom_range(99, 0) < ack_pct);
            instr_ready = ($urandom_range(99, 0) < rdy_pct);
            redirect_valid = ($urandom_range(99, 0) < 6);
            redirect_pc = $urandom;
            salt = $urandom;
            tick();
        end
        rst = 1'b0;
        redirect_valid = 1'b0;
        imem_ack = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
